float_to_int: RTL

FLOAT_TO_INT -- requirements
Module: float_to_int

---
 rtl/fp_pkg.sv | 18 +
 rtl/fp_unpack.sv | 36 +++
 rtl/float_to_int.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared float-format constants and FSM state type for the fp block family
// Contents: state_t (GET_A/UNPACK/CONVERT/PUT_Z), exponent bias, special exponent,
//           signed 32-bit integer limits.
package fp_pkg;

  typedef enum logic [1:0] {
    GET_A   = 2'd0,
    UNPACK  = 2'd1,
    CONVERT = 2'd2,
    PUT_Z   = 2'd3
  } state_t;

  localparam logic signed [9:0] EXP_BIAS    = 10'sd127;
  localparam logic [7:0]        EXP_SPECIAL = 8'hFF;
  localparam logic [31:0]       INT_MAX     = 32'h7FFFFFFF;
  localparam logic [31:0]       INT_MIN     = 32'h80000000;

endpackage

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational IEEE-754 single-precision field splitter
// Ports:
//   a       in  32  single-precision operand
//   sign    out 1   sign bit
//   exp_unb out 10  unbiased exponent (signed, exp field - 127)
//   mant    out 24  mantissa with hidden one prepended
//   zero    out 1   exponent field is zero (zero or denormal)
//   inf     out 1   infinity
//   nan     out 1   not-a-number
module fp_unpack
  import fp_pkg::*;
(
  input  logic [31:0]       a,
  output logic              sign,
  output logic signed [9:0] exp_unb,
  output logic [23:0]       mant,
  output logic              zero,
  output logic              inf,
  output logic              nan
);

  logic [7:0]  exp_field;
  logic [22:0] frac;

  assign exp_field = a[30:23];
  assign frac      = a[22:0];

  assign sign    = a[31];
  assign exp_unb = $signed({2'b00, exp_field}) - EXP_BIAS;
  // The hidden one is always prepended; denormals are caught by the zero flag.
  assign mant    = {1'b1, frac};
  assign zero    = (exp_field == 8'h00);
  assign inf     = (exp_field == EXP_SPECIAL) && (frac == 23'd0);
  assign nan     = (exp_field == EXP_SPECIAL) && (frac != 23'd0);

endmodule

// File: rtl/float_to_int.sv
// rtl/float_to_int.sv - handshaked single-precision float to signed 32-bit integer converter
// Parameter SATURATE: 1 = out-of-range clamps by sign, 0 = out-of-range gives 32'h80000000.
// Ports:
//   clk           in  1   clock, rising edge
//   rst           in  1   asynchronous active-low reset
//   input_a       in  32  float operand
//   input_a_stb   in  1   operand valid
//   input_a_ack   out 1   ready for operand (registered)
//   output_z      out 32  truncated integer result (registered)
//   output_z_stb  out 1   result valid (registered)
//   output_z_ack  in  1   consumer accepts result
module float_to_int
  import fp_pkg::*;
#(
  parameter int SATURATE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] input_a,
  input  logic        input_a_stb,
  output logic        input_a_ack,
  output logic [31:0] output_z,
  output logic        output_z_stb,
  input  logic        output_z_ack
);

  state_t state, state_next;

  logic [31:0]       a_reg;
  logic              sign_r, zero_r, inf_r, nan_r;
  logic signed [9:0] exp_r;
  logic [23:0]       mant_r;

  logic              u_sign, u_zero, u_inf, u_nan;
  logic signed [9:0] u_exp;
  logic [23:0]       u_mant;

  logic        in_xfer, out_xfer;
  logic [4:0]  shl, shr;
  logic [31:0] magnitude, sat_val, result;
  logic        ack_next, stb_next;
  logic [31:0] z_next;

  assign in_xfer  = input_a_stb && input_a_ack;
  assign out_xfer = output_z_stb && output_z_ack;

  fp_unpack u_unpack (
    .a       (a_reg),
    .sign    (u_sign),
    .exp_unb (u_exp),
    .mant    (u_mant),
    .zero    (u_zero),
    .inf     (u_inf),
    .nan     (u_nan)
  );

  // State and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= GET_A;
      input_a_ack  <= 1'b0;
      output_z     <= 32'd0;
      output_z_stb <= 1'b0;
      a_reg        <= 32'd0;
      sign_r       <= 1'b0;
      exp_r        <= 10'sd0;
      mant_r       <= 24'd0;
      zero_r       <= 1'b0;
      inf_r        <= 1'b0;
      nan_r        <= 1'b0;
    end else begin
      state        <= state_next;
      input_a_ack  <= ack_next;
      output_z     <= z_next;
      output_z_stb <= stb_next;
      if (state == GET_A && in_xfer) begin
        a_reg <= input_a;
      end
      if (state == UNPACK) begin
        sign_r <= u_sign;
        exp_r  <= u_exp;
        mant_r <= u_mant;
        zero_r <= u_zero;
        inf_r  <= u_inf;
        nan_r  <= u_nan;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      GET_A:   if (in_xfer) state_next = UNPACK;
      UNPACK:  state_next = CONVERT;
      CONVERT: state_next = PUT_Z;
      PUT_Z:   if (out_xfer) state_next = GET_A;
      default: state_next = GET_A;
    endcase
  end

  // Conversion datapath. Mantissa binary point sits after bit 23, so the
  // integer part is mant shifted by (e - 23); only evaluated for 0 <= e <= 30.
  always_comb begin
    shl       = exp_r[4:0] - 5'd23;
    shr       = 5'd23 - exp_r[4:0];
    magnitude = (exp_r >= 10'sd23) ? ({8'd0, mant_r} << shl)
                                   : ({8'd0, mant_r} >> shr);
    sat_val   = (SATURATE != 0) ? (sign_r ? INT_MIN : INT_MAX) : INT_MIN;
    if (nan_r) begin
      result = INT_MIN;
    end else if (inf_r || exp_r > 10'sd30) begin
      result = sat_val;
    end else if (zero_r || exp_r < 10'sd0) begin
      result = 32'd0;
    end else begin
      result = sign_r ? -magnitude : magnitude;
    end
  end

  // Output next-values; ack is high exactly while the FSM sits in GET_A,
  // so it rises on the edge that enters GET_A (including the first after reset).
  always_comb begin
    ack_next = (state_next == GET_A);
    z_next   = output_z;
    stb_next = output_z_stb;
    case (state)
      CONVERT: begin
        z_next   = result;
        stb_next = 1'b1;
      end
      PUT_Z: begin
        if (out_xfer) stb_next = 1'b0;
      end
      default: begin
      end
    endcase
  end

endmodule
